// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: master state encoding, completion status codes
// and the TM line encodings used by both master and slave cards.
package nubus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_DONE
  } mst_state_e;

  // Completion status as seen on {TM1*, TM0*} when ACK* is asserted.
  localparam logic [1:0] ST_OK    = 2'b11;
  localparam logic [1:0] ST_ERR   = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b01;
  localparam logic [1:0] ST_RETRY = 2'b00;

  // Transfer-type encodings {TM1*, TM0*} driven alongside START*.
  localparam logic [1:0] TM_WR_WORD = 2'b01;
  localparam logic [1:0] TM_RD_WORD = 2'b11;

  localparam int unsigned ARB_WIN_CYCLES = 2;

  function automatic logic [1:0] start_tm(input logic write);
    return write ? TM_WR_WORD : TM_RD_WORD;
  endfunction

endpackage

// File: rtl/nubus_arb.sv
// NuBus arbitration front end: RQST*/ARB* drive, bus-idle tracking and the
// two-cycle qualification that declares this card the winner.
module nubus_arb
  import nubus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       arb_en,
  input  logic [3:0] id_i,
  input  logic       startn_i,
  input  logic       ackn_i,
  input  logic [3:0] arbn_i,
  output logic       rqstn_o,
  output logic [3:0] arbn_o,
  output logic       win_o
);

  logic       bus_idle_q, bus_idle_d;
  logic [1:0] match_cnt_q, match_cnt_d;
  logic       match;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    bus_idle_d  = bus_idle_q;
    match_cnt_d = 2'd0;
    win_o       = 1'b0;

    // ACK ends any tenure; a START without ACK opens one.
    if (!ackn_i) begin
      bus_idle_d = 1'b1;
    end else if (!startn_i) begin
      bus_idle_d = 1'b0;
    end

    match = arb_en && bus_idle_q && (arbn_i == ~id_i);
    if (match) begin
      if (match_cnt_q == 2'(ARB_WIN_CYCLES - 1)) begin
        win_o       = 1'b1;
        match_cnt_d = match_cnt_q;
      end else begin
        match_cnt_d = match_cnt_q + 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_idle_q  <= 1'b1;
      match_cnt_q <= 2'd0;
    end else begin
      bus_idle_q  <= bus_idle_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign rqstn_o = ~arb_en;
  assign arbn_o  = arb_en ? ~id_i : 4'hF;

endmodule

// File: rtl/nubus_master.sv
// NuBus single-word master: accepts a local request, arbitrates, runs one
// START/DATA tenure and reports read data plus completion status.
module nubus_master
  import nubus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mst_req_i,
  input  logic        mst_write_i,
  input  logic [31:0] mst_addr_i,
  input  logic [31:0] mst_wdata_i,
  output logic        mst_ack_o,
  output logic        mst_done_o,
  output logic [31:0] mst_rdata_o,
  output logic [1:0]  mst_status_o,
  output logic        busy_o,
  input  logic [3:0]  nub_id_i,
  input  logic        nub_startn_i,
  input  logic        nub_ackn_i,
  input  logic        nub_rqstn_i,
  input  logic [3:0]  nub_arbn_i,
  input  logic [31:0] nub_ad_i,
  input  logic        nub_tm1n_i,
  input  logic        nub_tm0n_i,
  output logic        nub_startn_o,
  output logic        nub_rqstn_o,
  output logic [3:0]  nub_arbn_o,
  output logic [31:0] nub_ad_o,
  output logic        nub_ad_oe_o,
  output logic        nub_tm1n_o,
  output logic        nub_tm0n_o,
  output logic        nub_tm_oe_o
);

  // DATA begins the cycle after ADDR, so terminating on this count lands
  // DONE exactly TIMEOUT cycles after ADDR.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 2);

  mst_state_e  state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        write_q, write_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  status_q, status_d;
  logic        arb_win;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^mst_addr_i[1:0];

  nubus_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (state_q == S_ARB),
    .id_i     (nub_id_i),
    .startn_i (nub_startn_i),
    .ackn_i   (nub_ackn_i),
    .arbn_i   (nub_arbn_i),
    .rqstn_o  (nub_rqstn_o),
    .arbn_o   (nub_arbn_o),
    .win_o    (arb_win)
  );

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    mst_ack_o    = 1'b0;
    nub_startn_o = 1'b1;
    nub_ad_o     = '1;
    nub_ad_oe_o  = 1'b0;
    nub_tm1n_o   = 1'b1;
    nub_tm0n_o   = 1'b1;
    nub_tm_oe_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mst_req_i && nub_rqstn_i) begin
          mst_ack_o = 1'b1;
          write_d   = mst_write_i;
          addr_d    = mst_addr_i[31:2];
          wdata_d   = mst_wdata_i;
          state_d   = S_ARB;
        end
      end
      S_ARB: begin
        if (arb_win) state_d = S_ADDR;
      end
      S_ADDR: begin
        nub_startn_o             = 1'b0;
        nub_ad_o                 = ~{addr_q, 2'b00};
        nub_ad_oe_o              = 1'b1;
        {nub_tm1n_o, nub_tm0n_o} = start_tm(write_q);
        nub_tm_oe_o              = 1'b1;
        tmo_cnt_d                = 8'd0;
        state_d                  = S_DATA;
      end
      S_DATA: begin
        nub_ad_o    = write_q ? ~wdata_q : '1;
        nub_ad_oe_o = write_q;
        tmo_cnt_d   = tmo_cnt_q + 8'd1;
        // ACK takes priority over a coincident terminal count.
        if (!nub_ackn_i) begin
          if (!write_q) rdata_d = ~nub_ad_i;
          status_d = {nub_tm1n_i, nub_tm0n_i};
          state_d  = S_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          status_d = ST_TMO;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: result registers take a defined reset value so software reading
  // status before any transaction sees OK rather than X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= 8'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
    end
  end

  assign mst_done_o   = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE) || mst_ack_o;
  assign mst_rdata_o  = rdata_q;
  assign mst_status_o = status_q;

endmodule

// File: tb/tb_nubus_master.sv
// Directed plus randomized bench for nubus_master with a simple bus/responder
// model and a transaction-level expectation of rdata/status.
module tb_nubus_master;
  import nubus_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mst_req_i, mst_write_i;
  logic [31:0] mst_addr_i, mst_wdata_i;
  logic        mst_ack_o, mst_done_o, busy_o;
  logic [31:0] mst_rdata_o;
  logic [1:0]  mst_status_o;
  logic [3:0]  nub_id_i;
  logic        nub_startn_i, nub_ackn_i, nub_rqstn_i;
  logic [3:0]  nub_arbn_i;
  logic [31:0] nub_ad_i;
  logic        nub_tm1n_i, nub_tm0n_i;
  logic        nub_startn_o, nub_rqstn_o;
  logic [3:0]  nub_arbn_o;
  logic [31:0] nub_ad_o;
  logic        nub_ad_oe_o, nub_tm1n_o, nub_tm0n_o, nub_tm_oe_o;

  // Other cards on the bus.
  logic        oth_rqstn, tb_startn, tb_ackn, tb_tm1n, tb_tm0n;
  logic [3:0]  oth_arbn;
  logic [31:0] tb_ad;

  assign nub_arbn_i   = nub_arbn_o & oth_arbn;
  assign nub_rqstn_i  = nub_rqstn_o & oth_rqstn;
  assign nub_startn_i = tb_startn;
  assign nub_ackn_i   = tb_ackn;
  assign nub_ad_i     = tb_ad;
  assign nub_tm1n_i   = tb_tm1n;
  assign nub_tm0n_i   = tb_tm0n;

  nubus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .mst_req_i(mst_req_i), .mst_write_i(mst_write_i),
    .mst_addr_i(mst_addr_i), .mst_wdata_i(mst_wdata_i),
    .mst_ack_o(mst_ack_o), .mst_done_o(mst_done_o),
    .mst_rdata_o(mst_rdata_o), .mst_status_o(mst_status_o), .busy_o(busy_o),
    .nub_id_i(nub_id_i), .nub_startn_i(nub_startn_i), .nub_ackn_i(nub_ackn_i),
    .nub_rqstn_i(nub_rqstn_i), .nub_arbn_i(nub_arbn_i), .nub_ad_i(nub_ad_i),
    .nub_tm1n_i(nub_tm1n_i), .nub_tm0n_i(nub_tm0n_i),
    .nub_startn_o(nub_startn_o), .nub_rqstn_o(nub_rqstn_o),
    .nub_arbn_o(nub_arbn_o), .nub_ad_o(nub_ad_o), .nub_ad_oe_o(nub_ad_oe_o),
    .nub_tm1n_o(nub_tm1n_o), .nub_tm0n_o(nub_tm0n_o), .nub_tm_oe_o(nub_tm_oe_o)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] model_rdata;
  logic [1:0]  model_status;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_released(input string tag);
    check(tag, {24'd0, nub_startn_o, nub_rqstn_o, nub_arbn_o, nub_ad_oe_o, nub_tm_oe_o},
          32'b1111_1100);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_rdata  = 32'd0;
    model_status = ST_OK;
  endtask

  // Presents a request and checks it is accepted in that same cycle.
  task automatic issue_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mst_req_i = 1'b1; mst_write_i = w; mst_addr_i = a; mst_wdata_i = d;
    #1;
    check("accept_ack", mst_ack_o, 1);
    check("accept_busy", busy_o, 1);
    @(negedge clk);
    mst_req_i = 1'b0; mst_write_i = ~w; mst_addr_i = ~a; mst_wdata_i = ~d;
    #1;
    check("ack_one_cycle", mst_ack_o, 0);
  endtask

  // Called just after a negedge+1; counts cycles until START* is driven.
  task automatic wait_addr(input int bound, output int lat, output logic found);
    lat = 1;
    found = 1'b0;
    while (!found && lat <= bound) begin
      if (nub_startn_o === 1'b0) begin
        found = 1'b1;
      end else begin
        check("arb_drive", {27'd0, nub_rqstn_o, nub_arbn_o}, {27'd0, 1'b0, ~nub_id_i});
        @(negedge clk);
        #1;
        lat++;
      end
    end
    check("addr_start_seen", found, 1);
  endtask

  task automatic addr_checks(input logic w, input logic [31:0] a);
    check("addr_ad", nub_ad_o, ~{a[31:2], 2'b00});
    check("addr_ad_oe", nub_ad_oe_o, 1);
    check("addr_tm", {29'd0, nub_tm1n_o, nub_tm0n_o, nub_tm_oe_o}, {29'd0, ~w, 1'b1, 1'b1});
    check("addr_arb_released", {27'd0, nub_rqstn_o, nub_arbn_o}, 32'h1F);
  endtask

  // Responder acks on DATA cycle ack_cyc (1-based); outside 1..TMO-1 never acks.
  task automatic data_phase(input logic w, input logic [31:0] d, input int ack_cyc,
                            input logic [31:0] resp, input logic [1:0] tm);
    logic acked = 1'b0;
    for (int i = 1; i <= int'(TMO) - 1 && !acked; i++) begin
      @(negedge clk);
      if (i == ack_cyc) begin
        tb_ackn = 1'b0; tb_ad = ~resp; {tb_tm1n, tb_tm0n} = tm;
        acked = 1'b1;
      end
      #1;
      check("data_ad_oe", nub_ad_oe_o, w);
      check("data_tm_oe", nub_tm_oe_o, 0);
      if (w) check("data_wdata", nub_ad_o, ~d);
      check("data_no_done", mst_done_o, 0);
    end
    @(negedge clk);
    tb_ackn = 1'b1; tb_ad = '1; {tb_tm1n, tb_tm0n} = 2'b11;
    #1;
    if (acked) begin
      model_status = tm;
      if (!w) model_rdata = resp;
    end else begin
      model_status = ST_TMO;
    end
    check("done_pulse", mst_done_o, 1);
    check("done_status", mst_status_o, model_status);
    check("done_rdata", mst_rdata_o, model_rdata);
    check("done_busy", busy_o, 1);
    check_released("done_released");
    @(negedge clk);
    #1;
    check("after_done", {30'd0, mst_done_o, busy_o}, 0);
    check("rdata_held", mst_rdata_o, model_rdata);
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int ack_cyc, input logic [31:0] resp, input logic [1:0] tm);
    int   lat;
    logic found;
    issue_req(w, a, d);
    wait_addr(10, lat, found);
    if (found) begin
      check("arb_latency", lat, 3);
      addr_checks(w, a);
      data_phase(w, d, ack_cyc, resp, tm);
    end else begin
      apply_reset();
    end
  endtask

  initial begin
    int   lat;
    logic found;
    reset = 1'b1;
    mst_req_i = 1'b0; mst_write_i = 1'b0; mst_addr_i = '0; mst_wdata_i = '0;
    nub_id_i = 4'h9;
    oth_rqstn = 1'b1; oth_arbn = 4'hF; tb_startn = 1'b1; tb_ackn = 1'b1;
    tb_ad = '1; tb_tm1n = 1'b1; tb_tm0n = 1'b1;
    model_rdata = 32'd0; model_status = ST_OK;
    #1;
    check("rst_outputs", {28'd0, mst_ack_o, mst_done_o, busy_o, 1'b0}, 0);
    check("rst_rdata", mst_rdata_o, 0);
    check("rst_status", mst_status_o, ST_OK);
    check_released("rst_released");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Write with ACK on 3rd DATA cycle; read returning CAFEF00D.
    run_txn(1'b1, 32'hF900_0010, 32'h1234_5678, 3, 32'h0, ST_OK);
    run_txn(1'b0, 32'hF000_0000, 32'h0, 2, 32'hCAFE_F00D, ST_OK);
    // Error write leaves rdata untouched; no-ACK read times out.
    run_txn(1'b1, 32'hF900_0123, 32'hA5A5_5A5A, 1, 32'h0, ST_ERR);
    run_txn(1'b0, 32'hF000_0040, 32'h0, 0, 32'hDEAD_BEEF, ST_OK);
    // ACK on the terminal-count cycle: sampled TM (try-again) must win.
    run_txn(1'b0, 32'hF000_0080, 32'h0, int'(TMO) - 1, 32'h0BAD_CAFE, ST_RETRY);

    // Competing card 0xB holds the bus.
    @(negedge clk);
    oth_arbn = ~4'hB; tb_startn = 1'b0;
    mst_req_i = 1'b1; mst_write_i = 1'b0; mst_addr_i = 32'hF000_0100;
    #1;
    check("comp_accept", mst_ack_o, 1);
    @(negedge clk);
    tb_startn = 1'b1; mst_req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("comp_no_start", nub_startn_o, 1);
      @(negedge clk);
    end
    oth_arbn = 4'hF; tb_ackn = 1'b0;
    #1;
    check("comp_no_start_ack", nub_startn_o, 1);
    @(negedge clk);
    tb_ackn = 1'b1;
    #1;
    wait_addr(3, lat, found);
    if (found) begin
      addr_checks(1'b0, 32'hF000_0100);
      data_phase(1'b0, 32'h0, 1, 32'h1357_9BDF, ST_OK);
    end else begin
      apply_reset();
    end

    // Reset pulsed in DATA drops the transaction.
    issue_req(1'b1, 32'hF900_0200, 32'h7777_8888);
    wait_addr(10, lat, found);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_released("rst_mid_released");
    check("rst_mid_done_busy", {30'd0, mst_done_o, busy_o}, 0);
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 32'd0; model_status = ST_OK;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rst_mid_no_done", mst_done_o, 0);
      @(negedge clk);
    end
    check("rst_mid_status", mst_status_o, model_status);
    run_txn(1'b0, 32'hF000_0300, 32'h0, 2, 32'h2468_ACE0, ST_OK);

    // Randomized transactions against the transaction-level expectation.
    for (int n = 0; n < 8; n++) begin
      logic        w;
      logic [31:0] a, d, r;
      logic [1:0]  tm;
      int          ac;
      nub_id_i = 4'($urandom_range(1, 14));
      w  = 1'($urandom);
      a  = $urandom;
      d  = $urandom;
      r  = $urandom;
      tm = 2'($urandom);
      ac = int'($urandom_range(0, 9));
      run_txn(w, a, d, ac, r, tm);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
